// File: rtl/audio_sample_ctrl.sv
// audio_sample_ctrl: derives the audio sample-rate tick from clk_sys, captures the
// stereo DAC words and queues them in a small FIFO behind a valid/ready handshake.
// It also keeps saturating overrun/underrun statistics.
module audio_sample_ctrl #(
   parameter int unsigned CLK_RATE    = 14_000_000,
   parameter int unsigned SAMPLE_RATE = 48_000,
   parameter int unsigned DW          = 10,
   parameter int unsigned DEPTH       = 4,
   parameter bit          SIGNED_OUT  = 1'b1
) (
   input  logic          i_clk_sys,
   input  logic          i_reset_n,
   input  logic [DW-1:0] i_dac_l,
   input  logic [DW-1:0] i_dac_r,
   input  logic          i_mute,
   input  logic          i_clear_stats,
   output logic          o_sample_valid,
   input  logic          i_sample_ready,
   output logic [15:0]   o_left_chan,
   output logic [15:0]   o_right_chan,
   output logic          o_tick,
   output logic [4:0]    o_fifo_level,
   output logic [7:0]    o_overrun_cnt,
   output logic [7:0]    o_underrun_cnt
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] LP_SR     = 32'(SAMPLE_RATE);
   localparam logic [31:0] LP_CR     = 32'(CLK_RATE);
   localparam logic [4:0]  LP_DEPTH  = 5'(DEPTH);

   // Left-justify a DAC word, substitute midscale on mute, optionally flip to signed.
   function automatic logic [15:0] fmt_word(input logic [DW-1:0] d, input logic m);
      logic [15:0] w;
      w = 16'(d) << (16 - DW);
      if (m) begin
         w = 16'h8000;
      end
      if (SIGNED_OUT) begin
         w[15] = ~w[15];
      end
      return w;
   endfunction

   logic [31:0]   r_acc;
   logic          r_tick;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [4:0]    r_level;
   logic [7:0]    r_overrun_cnt;
   logic [7:0]    r_underrun_cnt;
   logic          r_starved;

   logic [31:0]   w_nxt;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_overrun;
   logic          w_underrun;
   logic [31:0]   w_word;

   assign w_nxt      = r_acc + LP_SR;
   assign w_full     = (r_level == LP_DEPTH);
   assign w_pop      = o_sample_valid & i_sample_ready;
   // A full FIFO still takes the new sample when the head leaves on the same edge.
   assign w_push     = r_tick & (~w_full | w_pop);
   assign w_overrun  = r_tick & w_full & ~w_pop;
   assign w_underrun = i_sample_ready & ~o_sample_valid & ~r_starved;
   assign w_word     = {fmt_word(i_dac_l, i_mute), fmt_word(i_dac_r, i_mute)};

   assign o_sample_valid = (r_level != 5'd0);
   assign o_left_chan    = r_mem[r_rd_ptr][31:16];
   assign o_right_chan   = r_mem[r_rd_ptr][15:0];
   assign o_tick         = r_tick;
   assign o_fifo_level   = r_level;
   assign o_overrun_cnt  = r_overrun_cnt;
   assign o_underrun_cnt = r_underrun_cnt;

   // Fractional accumulator: exact average of SAMPLE_RATE ticks per CLK_RATE cycles.
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_acc  <= 32'd0;
         r_tick <= 1'b0;
      end else if (w_nxt >= LP_CR) begin
         r_acc  <= w_nxt - LP_CR;
         r_tick <= 1'b1;
      end else begin
         r_acc  <= w_nxt;
         r_tick <= 1'b0;
      end
   end

   // FIFO storage, pointers and occupancy.
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= 32'd0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= 5'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 5'd1;
         end else if (w_pop && !w_push) begin
            r_level <= r_level - 5'd1;
         end
      end
   end

   // Saturating statistics; clear takes priority over any coincident increment.
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_overrun_cnt  <= 8'd0;
         r_underrun_cnt <= 8'd0;
         r_starved      <= 1'b0;
      end else if (i_clear_stats) begin
         r_overrun_cnt  <= 8'd0;
         r_underrun_cnt <= 8'd0;
         r_starved      <= 1'b0;
      end else begin
         if (w_overrun && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
         end
         if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
         end
         // One count per starvation episode; the next accepted push ends it.
         if (w_push) begin
            r_starved <= 1'b0;
         end else if (w_underrun) begin
            r_starved <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_audio_sample_ctrl.sv
// Testbench for audio_sample_ctrl: randomized DAC data and handshake checked
// against a queue-based reference model, plus directed boundary steps.
module tb_audio_sample_ctrl;

   localparam int unsigned CLK_RATE    = 14_000_000;
   localparam int unsigned SAMPLE_RATE = 48_000;
   localparam int unsigned DW          = 10;
   localparam int unsigned DEPTH       = 4;
   localparam bit          SIGNED_OUT  = 1'b1;
   localparam longint      SR          = longint'(SAMPLE_RATE);
   localparam longint      CR          = longint'(CLK_RATE);

   logic          clk_sys;
   logic          reset_n;
   logic [DW-1:0] dac_l;
   logic [DW-1:0] dac_r;
   logic          mute;
   logic          clear_stats;
   logic          ready;
   logic          o_sample_valid;
   logic [15:0]   o_left_chan;
   logic [15:0]   o_right_chan;
   logic          o_tick;
   logic [4:0]    o_fifo_level;
   logic [7:0]    o_overrun_cnt;
   logic [7:0]    o_underrun_cnt;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // Reference model state
   logic [31:0] mq[$];
   longint      m_k;
   bit          m_tick;
   bit          m_starved;
   int unsigned m_ovr;
   int unsigned m_und;
   bit          rnd_dac;
   int unsigned dut_ticks;
   int unsigned dut_pops;
   int          first_tick;
   int unsigned ovr_before;

   audio_sample_ctrl #(
      .CLK_RATE    (CLK_RATE),
      .SAMPLE_RATE (SAMPLE_RATE),
      .DW          (DW),
      .DEPTH       (DEPTH),
      .SIGNED_OUT  (SIGNED_OUT)
   ) u_dut (
      .i_clk_sys      (clk_sys),
      .i_reset_n      (reset_n),
      .i_dac_l        (dac_l),
      .i_dac_r        (dac_r),
      .i_mute         (mute),
      .i_clear_stats  (clear_stats),
      .o_sample_valid (o_sample_valid),
      .i_sample_ready (ready),
      .o_left_chan    (o_left_chan),
      .o_right_chan   (o_right_chan),
      .o_tick         (o_tick),
      .o_fifo_level   (o_fifo_level),
      .o_overrun_cnt  (o_overrun_cnt),
      .o_underrun_cnt (o_underrun_cnt)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Output word from the arithmetic meaning of the format rules.
   function automatic logic [15:0] model_word(input logic [DW-1:0] d, input logic m);
      int unsigned v;
      v = int'(d) * (1 << (16 - DW));
      if (m) v = 32768;
      if (SIGNED_OUT) v = (v + 32768) % 65536;
      return 16'(v);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_k       = 0;
      m_tick    = 1'b0;
      m_starved = 1'b0;
      m_ovr     = 0;
      m_und     = 0;
   endtask

   // One clock cycle: predict from pre-edge state, advance, compare every output.
   task automatic cycle();
      bit          pre_valid, pop, push, ovr, und;
      logic [31:0] word;
      if (rnd_dac) begin
         dac_l = DW'($urandom);
         dac_r = DW'($urandom);
      end
      pre_valid = (mq.size() != 0);
      pop       = pre_valid && ready;
      push      = m_tick && ((mq.size() < int'(DEPTH)) || pop);
      ovr       = m_tick && !push;
      und       = ready && !pre_valid && !m_starved;
      word      = {model_word(dac_l, mute), model_word(dac_r, mute)};
      if (o_sample_valid && ready) dut_pops++;
      @(posedge clk_sys);
      #1;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(word);
      if (clear_stats) begin
         m_ovr     = 0;
         m_und     = 0;
         m_starved = 1'b0;
      end else begin
         if (ovr && m_ovr < 255) m_ovr++;
         if (und && m_und < 255) m_und++;
         if (push)     m_starved = 1'b0;
         else if (und) m_starved = 1'b1;
      end
      m_k++;
      m_tick = ((m_k * SR) / CR) != (((m_k - 1) * SR) / CR);
      if (o_tick) dut_ticks++;
      check("tick", 32'(o_tick), 32'(m_tick));
      check("valid", 32'(o_sample_valid), 32'(mq.size() != 0));
      check("level", 32'(o_fifo_level), 32'(mq.size()));
      check("overrun", 32'(o_overrun_cnt), m_ovr);
      check("underrun", 32'(o_underrun_cnt), m_und);
      if (mq.size() != 0) begin
         check("left", 32'(o_left_chan), 32'(mq[0][31:16]));
         check("right", 32'(o_right_chan), 32'(mq[0][15:0]));
      end
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 400; i++) begin
         cycle();
         if (o_tick) return;
      end
      vectors++;
      miscompares++;
      $error("FAIL wait_tick observed=no-tick expected=tick within 400 cycles");
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tick"}, 32'(o_tick), 32'd0);
      check({tag, "_valid"}, 32'(o_sample_valid), 32'd0);
      check({tag, "_level"}, 32'(o_fifo_level), 32'd0);
      check({tag, "_left"}, 32'(o_left_chan), 32'd0);
      check({tag, "_right"}, 32'(o_right_chan), 32'd0);
      check({tag, "_ovr"}, 32'(o_overrun_cnt), 32'd0);
      check({tag, "_und"}, 32'(o_underrun_cnt), 32'd0);
   endtask

   initial begin
      reset_n     = 1'b0;
      dac_l       = '0;
      dac_r       = '0;
      mute        = 1'b0;
      clear_stats = 1'b0;
      ready       = 1'b0;
      rnd_dac     = 1'b1;
      model_reset();

      // Reset state, then release between edges.
      repeat (3) @(posedge clk_sys);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // Free run with ready high: 12 ticks and 12 pops, first tick at edge 292.
      ready      = 1'b1;
      dut_ticks  = 0;
      dut_pops   = 0;
      first_tick = -1;
      for (int i = 1; i <= 3502; i++) begin
         cycle();
         if (o_tick && first_tick < 0) first_tick = i;
      end
      check("first_tick", 32'(first_tick), 32'd292);
      check("tick_count", dut_ticks, 32'd12);
      check("pop_count", dut_pops, 32'd12);
      check("run_overrun", 32'(o_overrun_cnt), 32'd0);

      // Formatting of extreme codes, then mute.
      rnd_dac = 1'b0;
      ready   = 1'b0;
      dac_l   = 10'h3FF;
      dac_r   = 10'h000;
      wait_tick();
      cycle();
      check("fmt_valid", 32'(o_sample_valid), 32'd1);
      check("fmt_left", 32'(o_left_chan), 32'h7FC0);
      check("fmt_right", 32'(o_right_chan), 32'h8000);
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      mute  = 1'b1;
      wait_tick();
      cycle();
      check("mute_left", 32'(o_left_chan), 32'h0000);
      check("mute_right", 32'(o_right_chan), 32'h0000);
      mute  = 1'b0;
      ready = 1'b1;
      cycle();

      // Six ticks against a stalled consumer: fill to DEPTH, two dropped.
      rnd_dac     = 1'b1;
      ready       = 1'b0;
      clear_stats = 1'b1;
      cycle();
      clear_stats = 1'b0;
      repeat (6) wait_tick();
      cycle();
      check("ovr_level", 32'(o_fifo_level), 32'd4);
      check("ovr_count", 32'(o_overrun_cnt), 32'd2);
      ready = 1'b1;
      repeat (4) cycle();
      check("drained_valid", 32'(o_sample_valid), 32'd0);

      // Full FIFO with a pop on the tick cycle: push accepted, no overrun.
      ready = 1'b0;
      repeat (4) wait_tick();
      cycle();
      check("full_level", 32'(o_fifo_level), 32'd4);
      ovr_before = m_ovr;
      wait_tick();
      ready = 1'b1;
      cycle();
      ready = 1'b0;
      check("coinc_level", 32'(o_fifo_level), 32'd4);
      check("coinc_ovr", 32'(o_overrun_cnt), ovr_before);
      ready = 1'b1;
      repeat (4) cycle();

      // Starvation episodes count once each; clear beats a coincident increment.
      ready = 1'b0;
      wait_tick();
      ready       = 1'b1;
      clear_stats = 1'b1;
      cycle();
      clear_stats = 1'b0;
      repeat (101) cycle();
      check("und_one", 32'(o_underrun_cnt), 32'd1);
      ready = 1'b0;
      wait_tick();
      cycle();
      ready = 1'b1;
      repeat (6) cycle();
      check("und_two", 32'(o_underrun_cnt), 32'd2);
      ready = 1'b0;
      wait_tick();
      cycle();
      ready = 1'b1;
      cycle();
      clear_stats = 1'b1;
      cycle();
      clear_stats = 1'b0;
      ready       = 1'b0;
      check("und_clear", 32'(o_underrun_cnt), 32'd0);

      // Asynchronous reset mid-stream at level 3.
      repeat (3) wait_tick();
      cycle();
      check("pre_rst_level", 32'(o_fifo_level), 32'd3);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk_sys);
      #1;
      reset_n    = 1'b1;
      ready      = 1'b1;
      first_tick = -1;
      for (int i = 1; i <= 300; i++) begin
         cycle();
         if (o_tick && first_tick < 0) first_tick = i;
      end
      check("rst_first_tick", 32'(first_tick), 32'd292);

      // Randomized traffic: bursty ready, occasional mute and clear.
      for (int i = 0; i < 6000; i++) begin
         if ((i % 700) < 350) ready = ($urandom_range(0, 7) < 5);
         else                 ready = ($urandom_range(0, 31) == 0);
         mute        = ($urandom_range(0, 7) == 0);
         clear_stats = ($urandom_range(0, 499) == 0);
         cycle();
      end
      clear_stats = 1'b0;
      mute        = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
